// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-bus, redirect and decode-side signals of the fetch queue.
interface fetch_queue_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int CW      = 3
);
  logic               ireq_valid;
  logic [ADDR_W-1:0]  ireq_addr;
  logic               iresp_data_ok;
  logic [INSTR_W-1:0] iresp_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               out_exc;
  logic [CW-1:0]      count;
  modport master (
    output ireq_valid, ireq_addr, out_valid, out_pc, out_instr, out_exc, count,
    input  iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  ireq_valid, ireq_addr, out_valid, out_pc, out_instr, out_exc, count,
    output iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: PC+4 prefetcher feeding a DEPTH-entry instruction FIFO, with redirect flush,
// in-flight response discard and misaligned-PC fault entries.
module fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;
  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic               halted_q, halted_d;
  logic               exc_pend_q, exc_pend_d;
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W-1:0]  pc_mem [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic               exc_mem [DEPTH];
  logic               redir, ok, mis, push_data, push_exc, push, pop, room;
  assign bus.ireq_valid = state_q != IDLE;
  assign bus.ireq_addr  = req_addr_q;
  assign bus.out_valid  = count_q != '0;
  assign bus.out_pc     = pc_mem[rd_q];
  assign bus.out_instr  = instr_mem[rd_q];
  assign bus.out_exc    = exc_mem[rd_q];
  assign bus.count      = count_q;
  always_comb begin
    redir      = bus.redirect_valid;
    ok         = bus.iresp_data_ok;
    mis        = |bus.redirect_pc[1:0];
    push_data  = state_q == REQ && ok && !redir;
    push_exc   = exc_pend_q && !redir;
    push       = push_data || push_exc;
    pop        = bus.out_valid && bus.out_ready && !redir;
    count_d    = redir ? '0 : count_q + CW'(push) - CW'(pop);
    wr_d       = redir ? '0 : wr_q + PW'(push);
    rd_d       = redir ? '0 : rd_q + PW'(pop);
    room       = count_d < CW'(DEPTH);
    fetch_pc_d = redir ? bus.redirect_pc : push_data ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
    halted_d   = redir ? mis : halted_q;
    exc_pend_d = redir && mis;
    state_d    = state_q;
    case (state_q)
      IDLE:    state_d = (!redir && !halted_q && room) ? REQ : IDLE;
      REQ:     state_d = redir ? (ok ? IDLE : DROP) : ok ? (room ? REQ : IDLE) : REQ;
      DROP:    state_d = ok ? IDLE : DROP;
      default: state_d = IDLE;
    endcase
    // fetch_pc is the address of every live request, so it is latched whenever REQ is (re)entered
    req_addr_d = state_d == REQ ? fetch_pc_d : req_addr_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      halted_q   <= 1'b0;
      exc_pend_q <= 1'b0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      halted_q   <= halted_d;
      exc_pend_q <= exc_pend_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]    <= fetch_pc_q;
      instr_mem[wr_q] <= push_exc ? '0 : bus.iresp_data;
      exc_mem[wr_q]   <= push_exc;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench; accepted bus responses are queued as expected heads and
// compared on every pop, alongside directed checks of bus, count and fault behaviour.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;
  logic [96:0] sb [$];
  fetch_queue_if #(.ADDR_W(64), .INSTR_W(32), .CW(CW)) bus ();
  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h8000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mk_instr(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9bdf;
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic [96:0] e;
    if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      if (sb.size() == 0) chk("unexpected_head", {bus.out_pc, bus.out_instr, bus.out_exc}, 0);
      else begin
        e = sb.pop_front();
        chk("head", {bus.out_pc, bus.out_instr, bus.out_exc}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic tick_resp();
    if (bus.ireq_valid) begin
      bus.iresp_data_ok = 1'b1;
      bus.iresp_data    = mk_instr(bus.ireq_addr);
      sb.push_back({bus.ireq_addr, mk_instr(bus.ireq_addr), 1'b0});
    end
    tick();
    bus.iresp_data_ok = 1'b0;
  endtask
  task automatic restart();
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.iresp_data_ok  = 1'b0;
    reset = 1'b0;
    tick();
    sb.delete();
    reset = 1'b1;
  endtask
  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.iresp_data_ok  = 1'b0;
    bus.iresp_data     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    tick();
    restart();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_ireq_valid", bus.ireq_valid, 0);
    chk("rst_out_exc", bus.out_exc, 0);
    // back-to-back fetch with zero-latency responses
    bus.out_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("b2b_ireq_valid", bus.ireq_valid, 1);
      chk("b2b_addr", bus.ireq_addr, 64'h8000_0000 + 64'(4 * i));
      chk("b2b_count_le1", bus.count <= 1, 1);
      if (i > 0) chk("b2b_out_valid", bus.out_valid, 1);
      tick_resp();
    end
    tick();
    chk("b2b_drained", sb.size(), 0);
    // full queue with decode stalled
    restart();
    for (int i = 0; i < 7; i++) tick_resp();
    chk("full_pushes", sb.size(), 4);
    chk("full_count", bus.count, 4);
    chk("full_ireq_idle", bus.ireq_valid, 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("pop1_count", bus.count, 3);
    chk("pop1_ireq_valid", bus.ireq_valid, 1);
    chk("pop1_addr", bus.ireq_addr, 64'h8000_0010);
    // redirect while a slow request is pending
    restart();
    bus.out_ready = 1'b1;
    tick();
    tick_resp();
    tick_resp();
    chk("slow_addr0", bus.ireq_addr, 64'h8000_0008);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_1000;
    chk("slow_addr1", bus.ireq_addr, 64'h8000_0008);
    tick();
    bus.redirect_valid = 1'b0;
    chk("drop_ireq_valid", bus.ireq_valid, 1);
    chk("drop_addr", bus.ireq_addr, 64'h8000_0008);
    chk("drop_count", bus.count, 0);
    chk("drop_out_valid", bus.out_valid, 0);
    tick();
    chk("drop_addr_held", bus.ireq_addr, 64'h8000_0008);
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data    = mk_instr(64'h8000_0008);
    tick();
    bus.iresp_data_ok = 1'b0;
    chk("dropped_out_valid", bus.out_valid, 0);
    chk("dropped_ireq_idle", bus.ireq_valid, 0);
    tick();
    chk("redir_ireq_valid", bus.ireq_valid, 1);
    chk("redir_addr", bus.ireq_addr, 64'h8000_1000);
    tick_resp();
    tick();
    chk("redir_drained", sb.size(), 0);
    // redirect coinciding with data_ok and a pop
    restart();
    tick();
    tick_resp();
    tick_resp();
    chk("pre_flush_count", bus.count, 2);
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_1100;
    bus.iresp_data_ok  = 1'b1;
    bus.iresp_data     = mk_instr(bus.ireq_addr);
    tick();
    sb.delete();
    bus.redirect_valid = 1'b0;
    bus.iresp_data_ok  = 1'b0;
    chk("flush_count", bus.count, 0);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_ireq_idle", bus.ireq_valid, 0);
    tick();
    chk("flush_next_addr", bus.ireq_addr, 64'h8000_1100);
    tick_resp();
    tick();
    chk("flush_drained", sb.size(), 0);
    // misaligned redirect produces one fault entry and halts fetch
    restart();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_2002;
    tick();
    bus.redirect_valid = 1'b0;
    chk("mis_ireq_idle", bus.ireq_valid, 0);
    sb.push_back({64'h8000_2002, 32'h0, 1'b1});
    tick();
    chk("mis_out_valid", bus.out_valid, 1);
    chk("mis_out_exc", bus.out_exc, 1);
    bus.out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("halt_ireq_idle", bus.ireq_valid, 0);
      chk("halt_out_valid", bus.out_valid, 0);
      tick();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_3000;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    chk("resume_ireq_valid", bus.ireq_valid, 1);
    chk("resume_addr", bus.ireq_addr, 64'h8000_3000);
    tick_resp();
    tick();
    chk("resume_drained", sb.size(), 0);
    // reset with a request outstanding and two entries queued
    restart();
    tick();
    tick_resp();
    tick_resp();
    chk("pre_rst_count", bus.count, 2);
    reset = 1'b0;
    tick();
    sb.delete();
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_ireq_idle", bus.ireq_valid, 0);
    reset = 1'b1;
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data    = mk_instr(64'h8000_0008);
    tick();
    bus.iresp_data_ok = 1'b0;
    chk("late_ok_count", bus.count, 0);
    chk("restart_ireq_valid", bus.ireq_valid, 1);
    chk("restart_addr", bus.ireq_addr, 64'h8000_0000);
    tick_resp();
    bus.out_ready = 1'b1;
    tick();
    chk("final_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
